// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam int unsigned MIN_DIV = 8;

  function automatic logic [3:0] data_bits_count(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - rx synchroniser, fall detect, bit-period counter and 3-sample voter
module uart_bit_sampler #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             half_i,
  input  logic             clr_i,
  output logic             rx_s_o,
  output logic             fall_o,
  output logic             sample_strobe_o,
  output logic             sample_bit_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [1:0]             hist_q;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       end_cnt;

  assign rx_s_o  = sync_q[SYNC_STAGES-1];
  assign fall_o  = rx_prev_q & ~rx_s_o;
  assign end_cnt = half_i ? ((div_i >> 1) - DIV_W'(1)) : (div_i - DIV_W'(1));

  // hist_q holds rx_s from the two cycles before the decision count
  assign sample_strobe_o = (cnt_q == end_cnt);
  assign sample_bit_o    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_o) | (hist_q[0] & rx_s_o);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i || (cnt_q >= end_cnt)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      hist_q    <= '1;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s_o;
      hist_q    <= {hist_q[0], rx_s_o};
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with AXIS-style byte output
module uart_rx_cfg #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SIM_DELAY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [7:0]       rx_byte_data,
  output logic [1:0]       rx_byte_user,
  output logic             rx_byte_valid,
  input  logic             rx_byte_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             break_det,
  output logic             rx_idle,
  output logic             rx_start
);
  import uart_pkg::*;

  // register updates are zero-delay; the parameter is kept for drop-in compatibility
  logic unused_sim_delay;
  assign unused_sim_delay = (SIM_DELAY != 0);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_clamped;
  logic [3:0]       nbits_q, nbits_d;
  logic [1:0]       par_q, par_d;
  logic             stop2_q, stop2_d, stop_idx_q, stop_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       sh_q, sh_d, data_q, data_d;
  logic             par_acc_q, par_acc_d, par_bit_q, par_bit_d;
  logic             par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic             idle_ok_q, idle_ok_d;
  logic [1:0]       user_q, user_d, emit_user;
  logic             valid_q, valid_d, overrun_q, overrun_d;
  logic             brk_q, brk_d, start_q, start_d;
  logic             emit, ovr_set, ferr_now, par_en;
  logic             rx_s, fall, strobe, sbit, clr;

  assign div_clamped = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign par_en      = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  assign clr         = (state_d != state_q) || ((state_q == ST_BRK_WAIT) && !rx_s);

  uart_bit_sampler #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .rx_i            (rx),
    .div_i           (div_q),
    .half_i          ((state_q == ST_START) || (state_q == ST_IDLE)),
    .clr_i           (clr),
    .rx_s_o          (rx_s),
    .fall_o          (fall),
    .sample_strobe_o (strobe),
    .sample_bit_o    (sbit)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    par_acc_d  = par_acc_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    emit       = 1'b0;
    brk_d      = 1'b0;
    start_d    = 1'b0;
    ferr_now   = frm_err_q | ~sbit;
    emit_user  = {ferr_now, par_err_q};
    idle_ok_d  = (state_q == ST_IDLE) ? (idle_ok_q | strobe) : 1'b0;
    case (state_q)
      ST_IDLE: if (fall) begin
        state_d = ST_START;
        div_d   = div_clamped;
        nbits_d = data_bits_count(cfg_data_bits);
        par_d   = cfg_parity;
        stop2_d = cfg_stop2;
      end
      ST_START: if (strobe) begin
        if (!sbit) begin
          state_d    = ST_DATA;
          start_d    = 1'b1;
          sh_d       = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_acc_d  = 1'b0;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: if (strobe) begin
        sh_d[bit_idx_q] = sbit;
        par_acc_d       = par_acc_q ^ sbit;
        if ({1'b0, bit_idx_q} == nbits_q - 4'd1) state_d = par_en ? ST_PARITY : ST_STOP;
        else bit_idx_d = bit_idx_q + 3'd1;
      end
      ST_PARITY: if (strobe) begin
        par_bit_d = sbit;
        par_err_d = (par_q == PAR_ODD) ? ~(par_acc_q ^ sbit) : (par_acc_q ^ sbit);
        state_d   = ST_STOP;
      end
      ST_STOP: if (strobe) begin
        // par_bit_q stays 0 when parity is disabled, so it only matters when present
        if (!stop_idx_q && (sh_q == 8'd0) && !par_bit_q && !sbit) begin
          brk_d   = 1'b1;
          emit    = 1'b1;
          state_d = ST_BRK_WAIT;
        end else if (stop2_q && !stop_idx_q) begin
          stop_idx_d = 1'b1;
          frm_err_d  = ferr_now;
        end else begin
          emit    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BRK_WAIT: if (strobe && rx_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    data_d  = data_q;
    user_d  = user_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (emit && (!valid_q || rx_byte_ready)) begin
      data_d  = sh_q;
      user_d  = emit_user;
      valid_d = 1'b1;
    end else if (emit) begin
      ovr_set = 1'b1;
    end else if (valid_q && rx_byte_ready) begin
      valid_d = 1'b0;
    end
    overrun_d = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_W'(MIN_DIV);
      nbits_q    <= 4'd8;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      bit_idx_q  <= '0;
      sh_q       <= '0;
      par_acc_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      idle_ok_q  <= 1'b1;
      data_q     <= '0;
      user_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      brk_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      bit_idx_q  <= bit_idx_d;
      sh_q       <= sh_d;
      par_acc_q  <= par_acc_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      idle_ok_q  <= idle_ok_d;
      data_q     <= data_d;
      user_q     <= user_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      brk_q      <= brk_d;
      start_q    <= start_d;
    end
  end

  assign rx_byte_data  = data_q;
  assign rx_byte_user  = user_q;
  assign rx_byte_valid = valid_q;
  assign overrun       = overrun_q;
  assign break_det     = brk_q;
  assign rx_start      = start_q;
  assign rx_idle       = (state_q == ST_IDLE) && idle_ok_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  rx_byte_data;
  logic [1:0]  rx_byte_user;
  logic        rx_byte_valid;
  logic        rx_byte_ready;
  logic        overrun;
  logic        overrun_clr;
  logic        break_det;
  logic        rx_idle;
  logic        rx_start;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DIV_W(16), .SYNC_STAGES(2), .SIM_DELAY(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rx_byte_data  (rx_byte_data),
    .rx_byte_user  (rx_byte_user),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte_ready (rx_byte_ready),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .break_det     (break_det),
    .rx_idle       (rx_idle),
    .rx_start      (rx_start)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_pulses = 0;
  int   break_pulses = 0;
  int   rise_cyc = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_start === 1'b1) start_pulses++;
    if (break_det === 1'b1) break_pulses++;
    if (rx_byte_valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = rx_byte_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int div, input int nbits, input logic [7:0] data,
                            input int par, input logic flip, input int nstop, input logic stop0);
    logic [7:0] d;
    logic       p;
    cfg_div       = 16'(div);
    cfg_data_bits = 2'(nbits - 5);
    cfg_parity    = 2'(par);
    cfg_stop2     = (nstop == 2);
    d = data & ((8'd1 << nbits) - 8'd1);
    p = ((par == 1) ? ~^d : ^d) ^ flip;
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (div) @(negedge clk);
    end
    if (par != 0) begin
      rx = p;
      repeat (div) @(negedge clk);
    end
    rx = stop0;
    repeat (div) @(negedge clk);
    if (nstop == 2) begin
      rx = 1'b1;
      repeat (div) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic consume(input string tag, input logic [7:0] d, input logic [1:0] u);
    check({tag, " valid"}, 32'(rx_byte_valid), 32'd1);
    check({tag, " data"}, 32'(rx_byte_data), 32'(d));
    check({tag, " user"}, 32'(rx_byte_user), 32'(u));
    rx_byte_ready = 1'b1;
    @(negedge clk);
    rx_byte_ready = 1'b0;
    @(negedge clk);
    check({tag, " drained"}, 32'(rx_byte_valid), 32'd0);
  endtask

  initial begin
    int s0, b0, t0, lat;
    rst = 1'b1; rx = 1'b1; rx_byte_ready = 1'b0; overrun_clr = 1'b0;
    cfg_div = 16'd16; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst valid", 32'(rx_byte_valid), 32'd0);
    check("rst data", 32'(rx_byte_data), 32'd0);
    check("rst user", 32'(rx_byte_user), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst break", 32'(break_det), 32'd0);
    check("rst start", 32'(rx_start), 32'd0);
    check("rst idle", 32'(rx_idle), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 at div 16: valid about 9.5*16 cycles after the start edge
    s0 = start_pulses;
    t0 = cyc;
    send_frame(16, 8, 8'hA5, 0, 1'b0, 1, 1'b1);
    lat = rise_cyc - t0;
    check("8N1 latency in range", 32'(lat >= 150 && lat <= 160), 32'd1);
    check("8N1 start pulses", 32'(start_pulses - s0), 32'd1);
    consume("8N1", 8'hA5, 2'b00);

    // 7E2 at div 20, correct then flipped parity
    send_frame(20, 7, 8'h35, 2, 1'b0, 2, 1'b1);
    consume("7E2", 8'h35, 2'b00);
    send_frame(20, 7, 8'h35, 2, 1'b1, 2, 1'b1);
    consume("7E2 bad parity", 8'h35, 2'b01);

    // 5O1 with stop bit low
    send_frame(20, 5, 8'h0A, 1, 1'b0, 1, 1'b0);
    consume("5O1 frame err", 8'h0A, 2'b10);

    // break: line low for two 5O1 frames
    b0 = break_pulses;
    rx = 1'b0;
    repeat (320) @(negedge clk);
    check("break pulses", 32'(break_pulses - b0), 32'd1);
    check("break not idle", 32'(rx_idle), 32'd0);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("brk_wait holds", 32'(rx_idle), 32'd0);
    repeat (35) @(negedge clk);
    check("brk_wait exits", 32'(rx_idle), 32'd1);
    consume("break byte", 8'h00, 2'b11);
    send_frame(20, 5, 8'h1F, 1, 1'b0, 1, 1'b1);
    consume("5O1 after break", 8'h1F, 2'b00);

    // start glitch of 3 cycles at div 16
    cfg_div = 16'd16; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    s0 = start_pulses;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch no start", 32'(start_pulses - s0), 32'd0);
    check("glitch no byte", 32'(rx_byte_valid), 32'd0);
    check("glitch idle", 32'(rx_idle), 32'd1);

    // overrun with ready held low
    send_frame(16, 8, 8'h11, 0, 1'b0, 1, 1'b1);
    send_frame(16, 8, 8'h22, 0, 1'b0, 1, 1'b1);
    check("overrun set", 32'(overrun), 32'd1);
    check("overrun held data", 32'(rx_byte_data), 32'h11);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    @(negedge clk);
    check("overrun cleared", 32'(overrun), 32'd0);
    consume("overrun byte", 8'h11, 2'b00);

    // reset in the middle of data bit 3 with a byte held
    send_frame(16, 8, 8'h33, 0, 1'b0, 1, 1'b1);
    check("held before reset", 32'(rx_byte_valid), 32'd1);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b0; repeat (16) @(negedge clk);
    rx = 1'b1; repeat (16) @(negedge clk);
    rx = 1'b0; repeat (16) @(negedge clk);
    rx = 1'b1; repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst valid", 32'(rx_byte_valid), 32'd0);
    check("midrst data", 32'(rx_byte_data), 32'd0);
    check("midrst user", 32'(rx_byte_user), 32'd0);
    check("midrst idle", 32'(rx_idle), 32'd1);
    check("midrst start", 32'(rx_start), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(16, 8, 8'h5A, 0, 1'b0, 1, 1'b1);
    consume("after reset", 8'h5A, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
